// File: rtl/slv_arb_pkg.sv
// Shared types and sizing helpers for the register-slave round-robin arbiter.
package slv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT      = 2'd2,
    LOCAL_ACK = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A disabled watchdog (timeout 0) still needs a 1-bit counter to stay legal.
  function automatic int wd_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping past N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int IW1 = IW + 1;
  localparam logic [IW:0] NV = IW1'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   win;
  logic [IW:0]    bi;
  logic [IW:0]    pos;
  logic [IW:0]    sum;

  assign dbl = {req, req};

  // win[i] is the request i positions above ptr; the doubled vector absorbs the wrap.
  always_comb begin
    win   = '0;
    bi    = '0;
    pos   = '0;
    sum   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      bi     = {1'b0, ptr} + IW1'(i);
      win[i] = dbl[bi];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (win[i]) begin
        found = 1'b1;
        pos   = IW1'(i);
      end
    end
    sum = {1'b0, ptr} + pos;
    if (sum >= NV) sum = sum - NV;
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/slv_rr_arb.sv
// Round-robin arbiter sharing one register-slave req/ack port among N_MST requesters.
//   state     | meaning
//   IDLE      | no access in flight; arbitrate among pending requests
//   ISSUE     | one-cycle downstream request pulse from the latched payload
//   WAIT      | payload held downstream; waiting for ack or watchdog expiry
//   LOCAL_ACK | no-op request answered locally with an error ack
module slv_rr_arb
  import slv_arb_pkg::*;
#(
  parameter int                    N_MST           = 4,
  parameter int                    ADDR_WIDTH      = 64,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    TIMEOUT_CYCLES  = DEFAULT_TIMEOUT,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RD_DATA = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          soft_rst,
  input  logic [N_MST-1:0]              mst_req_vld,
  input  logic [N_MST-1:0]              mst_wr_en,
  input  logic [N_MST-1:0]              mst_rd_en,
  input  logic [N_MST*ADDR_WIDTH-1:0]   mst_addr,
  input  logic [N_MST*DATA_WIDTH-1:0]   mst_wr_data,
  output logic [N_MST-1:0]              mst_ack_vld,
  output logic [N_MST-1:0]              mst_err,
  output logic [DATA_WIDTH-1:0]         mst_rd_data,
  output logic                          slv_soft_rst,
  output logic                          slv_req_vld,
  output logic                          slv_wr_en,
  output logic                          slv_rd_en,
  output logic [ADDR_WIDTH-1:0]         slv_addr,
  output logic [DATA_WIDTH-1:0]         slv_wr_data,
  input  logic                          slv_ack_vld,
  input  logic [DATA_WIDTH-1:0]         slv_rd_data,
  input  logic                          slv_err
);

  localparam int IDX_W = idx_width(N_MST);
  localparam int WD_W  = wd_width(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  wd_expired;
  logic [IDX_W-1:0]      grant_nxt;
  logic                  ack_any;
  logic                  err_bit;
  logic                  wd_soft;

  rr_pick #(
    .N  (N_MST),
    .IW (IDX_W)
  ) u_rr_pick (
    .req   (mst_req_vld),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES));
  assign grant_nxt  = (grant_q == IDX_W'(N_MST - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          for (int i = 0; i < N_MST; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              wr_d    = mst_wr_en[i];
              rd_d    = mst_rd_en[i];
              addr_d  = mst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = mst_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = (wr_d || rd_d) ? ISSUE : LOCAL_ACK;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // An ack landing in the expiry cycle takes precedence over the abort.
        if (slv_ack_vld || wd_expired) begin
          rr_ptr_d = grant_nxt;
          state_d  = IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      LOCAL_ACK: begin
        rr_ptr_d = grant_nxt;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (soft_rst) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
      wd_d     = '0;
    end
  end

  always_comb begin
    slv_req_vld = 1'b0;
    slv_wr_en   = 1'b0;
    slv_rd_en   = 1'b0;
    slv_addr    = '0;
    slv_wr_data = '0;
    ack_any     = 1'b0;
    err_bit     = 1'b0;
    mst_rd_data = '0;
    wd_soft     = 1'b0;
    case (state_q)
      ISSUE, WAIT: begin
        slv_req_vld = (state_q == ISSUE);
        slv_wr_en   = wr_q;
        slv_rd_en   = rd_q && !wr_q;
        slv_addr    = addr_q;
        slv_wr_data = wdata_q;
        if (state_q == WAIT) begin
          if (slv_ack_vld) begin
            ack_any     = 1'b1;
            err_bit     = slv_err;
            mst_rd_data = slv_rd_data;
          end else if (wd_expired) begin
            ack_any     = 1'b1;
            err_bit     = 1'b1;
            mst_rd_data = TIMEOUT_RD_DATA;
            wd_soft     = 1'b1;
          end
        end
      end
      LOCAL_ACK: begin
        ack_any     = 1'b1;
        err_bit     = 1'b1;
        mst_rd_data = TIMEOUT_RD_DATA;
      end
      default: ;
    endcase
    // A soft reset drops the in-flight access without acknowledging it.
    if (soft_rst) begin
      ack_any     = 1'b0;
      err_bit     = 1'b0;
      mst_rd_data = '0;
    end
    slv_soft_rst = soft_rst || wd_soft;
    for (int i = 0; i < N_MST; i++) begin
      mst_ack_vld[i] = ack_any && (grant_q == IDX_W'(i));
      mst_err[i]     = ack_any && err_bit && (grant_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_slv_rr_arb.sv
// Directed bench for slv_rr_arb with hand-computed expectations.
module tb_slv_rr_arb;
  import slv_arb_pkg::*;

  localparam int          N  = 4;
  localparam int          AW = 64;
  localparam int          DW = 32;
  localparam int          TO = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            soft_rst;
  logic [N-1:0]    mst_req_vld;
  logic [N-1:0]    mst_wr_en;
  logic [N-1:0]    mst_rd_en;
  logic [N*AW-1:0] mst_addr;
  logic [N*DW-1:0] mst_wr_data;
  logic [N-1:0]    mst_ack_vld;
  logic [N-1:0]    mst_err;
  logic [DW-1:0]   mst_rd_data;
  logic            slv_soft_rst;
  logic            slv_req_vld;
  logic            slv_wr_en;
  logic            slv_rd_en;
  logic [AW-1:0]   slv_addr;
  logic [DW-1:0]   slv_wr_data;
  logic            slv_ack_vld;
  logic [DW-1:0]   slv_rd_data;
  logic            slv_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  slv_rr_arb #(
    .N_MST           (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .TIMEOUT_CYCLES  (TO),
    .TIMEOUT_RD_DATA (TO_DATA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst     (soft_rst),
    .mst_req_vld  (mst_req_vld),
    .mst_wr_en    (mst_wr_en),
    .mst_rd_en    (mst_rd_en),
    .mst_addr     (mst_addr),
    .mst_wr_data  (mst_wr_data),
    .mst_ack_vld  (mst_ack_vld),
    .mst_err      (mst_err),
    .mst_rd_data  (mst_rd_data),
    .slv_soft_rst (slv_soft_rst),
    .slv_req_vld  (slv_req_vld),
    .slv_wr_en    (slv_wr_en),
    .slv_rd_en    (slv_rd_en),
    .slv_addr     (slv_addr),
    .slv_wr_data  (slv_wr_data),
    .slv_ack_vld  (slv_ack_vld),
    .slv_rd_data  (slv_rd_data),
    .slv_err      (slv_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    mst_req_vld[i]         = 1'b1;
    mst_wr_en[i]           = wr;
    mst_rd_en[i]           = rd;
    mst_addr[i*AW +: AW]   = a;
    mst_wr_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    soft_rst    = 1'b0;
    mst_req_vld = '0;
    mst_wr_en   = '0;
    mst_rd_en   = '0;
    mst_addr    = '0;
    mst_wr_data = '0;
    slv_ack_vld = 1'b0;
    slv_rd_data = '0;
    slv_err     = 1'b0;
    #1;
    chk("rst_ack",     64'(mst_ack_vld), 64'h0);
    chk("rst_err",     64'(mst_err), 64'h0);
    chk("rst_rdata",   64'(mst_rd_data), 64'h0);
    chk("rst_req",     64'(slv_req_vld), 64'h0);
    chk("rst_addr",    64'(slv_addr), 64'h0);
    chk("rst_softrst", 64'(slv_soft_rst), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // All four read at once: grants 0,1,2,3 with one IDLE cycle between them.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 64'h100 + 64'(i), 32'h0);
    for (int k = 0; k < N; k++) begin
      step();
      chk("rd_issue_req",  64'(slv_req_vld), 64'h1);
      chk("rd_issue_rd",   64'(slv_rd_en), 64'h1);
      chk("rd_issue_addr", 64'(slv_addr), 64'h100 + 64'(k));
      step();
      chk("rd_wait_req", 64'(slv_req_vld), 64'h0);
      slv_ack_vld = 1'b1;
      slv_rd_data = 32'hA0 + 32'(k);
      slv_err     = (k == 2);
      #1;
      chk("rd_ack",   64'(mst_ack_vld), 64'(4'b0001 << k));
      chk("rd_data",  64'(mst_rd_data), 64'hA0 + 64'(k));
      chk("rd_err",   64'(mst_err), (k == 2) ? 64'h4 : 64'h0);
      step();
      slv_ack_vld    = 1'b0;
      slv_err        = 1'b0;
      mst_req_vld[k] = 1'b0;
      #1;
      chk("rd_gap_ack",   64'(mst_ack_vld), 64'h0);
      chk("rd_gap_rdata", 64'(mst_rd_data), 64'h0);
      chk("rd_gap_req",   64'(slv_req_vld), 64'h0);
    end

    // Single write from requester 2.
    set_req(2, 1'b1, 1'b0, 64'h1234, 32'hCAFE_0002);
    step();
    chk("wr_issue_req",  64'(slv_req_vld), 64'h1);
    chk("wr_issue_wr",   64'(slv_wr_en), 64'h1);
    chk("wr_issue_rd",   64'(slv_rd_en), 64'h0);
    chk("wr_issue_addr", 64'(slv_addr), 64'h1234);
    chk("wr_issue_data", 64'(slv_wr_data), 64'hCAFE_0002);
    chk("wr_issue_ack",  64'(mst_ack_vld), 64'h0);
    step();
    slv_ack_vld = 1'b1;
    slv_rd_data = 32'h0;
    #1;
    chk("wr_ack", 64'(mst_ack_vld), 64'h4);
    chk("wr_err", 64'(mst_err), 64'h0);
    step();
    slv_ack_vld    = 1'b0;
    mst_req_vld[2] = 1'b0;
    #1;
    chk("wr_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);

    // Fairness: 0 and 1 requesting back to back from rr_ptr=3.
    set_req(0, 1'b0, 1'b1, 64'h200, 32'h0);
    set_req(1, 1'b0, 1'b1, 64'h201, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair_issue_addr", 64'(slv_addr), 64'h200 + 64'(k % 2));
      step();
      slv_ack_vld = 1'b1;
      slv_rd_data = 32'(k);
      #1;
      chk("fair_ack", 64'(mst_ack_vld), 64'(4'b0001 << (k % 2)));
      step();
      slv_ack_vld = 1'b0;
      #1;
    end
    mst_req_vld = '0;

    // Watchdog: requester 3 with both enables (write wins), slave silent.
    set_req(3, 1'b1, 1'b1, 64'h3000, 32'h3333_3333);
    step();
    chk("to_issue_req", 64'(slv_req_vld), 64'h1);
    chk("to_issue_wr",  64'(slv_wr_en), 64'h1);
    chk("to_issue_rd",  64'(slv_rd_en), 64'h0);
    for (int i = 0; i < TO; i++) begin
      step();
      chk("to_silent_ack",  64'(mst_ack_vld), 64'h0);
      chk("to_silent_srst", 64'(slv_soft_rst), 64'h0);
    end
    step();
    chk("to_ack",   64'(mst_ack_vld), 64'h8);
    chk("to_err",   64'(mst_err), 64'h8);
    chk("to_rdata", 64'(mst_rd_data), 64'(TO_DATA));
    chk("to_srst",  64'(slv_soft_rst), 64'h1);
    step();
    mst_req_vld[3] = 1'b0;
    #1;
    chk("to_after_srst", 64'(slv_soft_rst), 64'h0);
    chk("to_after_ack",  64'(mst_ack_vld), 64'h0);
    set_req(0, 1'b0, 1'b1, 64'h400, 32'h0);
    step();
    chk("post_to_req", 64'(slv_req_vld), 64'h1);
    step();
    slv_ack_vld = 1'b1;
    slv_rd_data = 32'h55;
    #1;
    chk("post_to_ack",   64'(mst_ack_vld), 64'h1);
    chk("post_to_rdata", 64'(mst_rd_data), 64'h55);
    chk("post_to_err",   64'(mst_err), 64'h0);
    step();
    slv_ack_vld    = 1'b0;
    mst_req_vld[0] = 1'b0;
    #1;

    // No-op on requester 1 answered locally.
    set_req(1, 1'b0, 1'b0, 64'h500, 32'h0);
    step();
    chk("noop_req",   64'(slv_req_vld), 64'h0);
    chk("noop_ack",   64'(mst_ack_vld), 64'h2);
    chk("noop_err",   64'(mst_err), 64'h2);
    chk("noop_rdata", 64'(mst_rd_data), 64'(TO_DATA));
    step();
    mst_req_vld[1] = 1'b0;
    #1;
    chk("noop_after_ack", 64'(mst_ack_vld), 64'h0);
    chk("noop_after_req", 64'(slv_req_vld), 64'h0);

    // soft_rst in WAIT drops the access even with a concurrent ack.
    set_req(2, 1'b0, 1'b1, 64'h600, 32'h0);
    step();
    chk("srst_issue_req", 64'(slv_req_vld), 64'h1);
    step();
    soft_rst    = 1'b1;
    slv_ack_vld = 1'b1;
    slv_err     = 1'b1;
    slv_rd_data = 32'h77;
    #1;
    chk("srst_ack",   64'(mst_ack_vld), 64'h0);
    chk("srst_err",   64'(mst_err), 64'h0);
    chk("srst_rdata", 64'(mst_rd_data), 64'h0);
    chk("srst_out",   64'(slv_soft_rst), 64'h1);
    step();
    soft_rst       = 1'b0;
    slv_ack_vld    = 1'b0;
    slv_err        = 1'b0;
    mst_req_vld[2] = 1'b0;
    #1;
    chk("srst_state",  64'(dut.state_q), 64'(IDLE));
    chk("srst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    chk("srst_out_clr", 64'(slv_soft_rst), 64'h0);

    // rr_ptr back at 0 means requester 0 beats 3; then rst_n mid-ISSUE.
    set_req(0, 1'b0, 1'b1, 64'hA0A0, 32'h0);
    set_req(3, 1'b0, 1'b1, 64'h3333, 32'h0);
    step();
    chk("ptr0_issue_addr", 64'(slv_addr), 64'hA0A0);
    rst_n = 1'b0;
    #1;
    chk("arst_req",  64'(slv_req_vld), 64'h0);
    chk("arst_rd",   64'(slv_rd_en), 64'h0);
    chk("arst_addr", 64'(slv_addr), 64'h0);
    chk("arst_ack",  64'(mst_ack_vld), 64'h0);
    mst_req_vld = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("arst_after_req", 64'(slv_req_vld), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
